// File: rtl/chiplet_types_pkg.sv
// Shared chiplet link types: flit layout, packet format codes and the
// header length decode used by the route, switch and output-port stages.
package chiplet_types_pkg;

  localparam int FLIT_VC_W      = 4;
  localparam int FLIT_PAYLOAD_W = 32;

  localparam logic [3:0] FMT_SHORT_READ  = 4'h0;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'h1;
  localparam logic [3:0] FMT_LONG_READ   = 4'h2;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'h3;

  typedef struct packed {
    logic [FLIT_VC_W-1:0]      vc;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic {OP_IDLE, OP_BODY} op_state_e;

  // Total flits in a packet including the header; worst case 127 + 2 = 129.
  function automatic logic [7:0] pkt_total_flits(flit_t hdr);
    logic [7:0] total;
    case (hdr.payload[31:28])
      FMT_SHORT_READ, FMT_SHORT_WRITE: total = {4'd0, hdr.payload[3:0]} + 8'd1;
      FMT_LONG_READ, FMT_LONG_WRITE:   total = {1'b0, hdr.payload[6:0]} + 8'd2;
      default:                         total = {1'b0, hdr.payload[6:0]} + 8'd1;
    endcase
    return total;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small power-of-two skid FIFO; full/empty come straight from the pointer
// registers so a same-cycle pop never changes them combinationally.
module flit_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  T                 wdata,
  output T                 rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;

endmodule

// File: rtl/switch_out_port.sv
// Switch output port: skid FIFO, per-VC credit gating, and packet framing
// that holds the link on one VC until the packet's last flit leaves.
module switch_out_port
  import chiplet_types_pkg::*;
#(
  parameter int  NUM_VCS     = 2,
  parameter int  BUFFER_SIZE = 8,
  parameter int  FIFO_DEPTH  = 2,
  localparam int VCW         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  flit_t                       in_flit,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_VCS-1:0]          credit_granted,
  output flit_t                       out_flit,
  output logic                        out_valid,
  output logic                        packet_sent,
  output logic [VCW-1:0]              packet_sent_vc,
  output logic [NUM_VCS-1:0][CW-1:0]  credits,
  output logic                        credit_overflow
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  flit_t                      head;
  logic                       fifo_full, fifo_empty, issue;
  logic [FCW-1:0]             fifo_cnt;
  logic [VCW-1:0]             hv;
  logic                       has_credit, permit;
  logic [7:0]                 total;

  op_state_e                  state_q, state_d;
  logic [7:0]                 rem_q, rem_d;
  logic [VCW-1:0]             lock_q, lock_d;
  flit_t                      out_flit_q;
  logic                       out_valid_q, ps_q, ps_d;
  logic [VCW-1:0]             psvc_q, psvc_d;
  logic [NUM_VCS-1:0][CW-1:0] cred_q;
  logic [NUM_VCS-1:0]         inc, dec;
  logic                       ovf_q, ovf_hit;

  flit_fifo #(.DEPTH(FIFO_DEPTH), .T(flit_t)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (in_valid),
    .pop   (issue),
    .wdata (in_flit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign in_ready = !fifo_full;
  assign hv       = head.vc[VCW-1:0];
  assign total    = pkt_total_flits(head);

  // Loop compare instead of cred_q[hv] so a non-power-of-two VC count never indexes out of range.
  always_comb begin
    has_credit = 1'b0;
    for (int v = 0; v < NUM_VCS; v++)
      if (hv == VCW'(v) && cred_q[v] != '0) has_credit = 1'b1;
  end

  assign permit = (state_q == OP_IDLE) || (hv == lock_q);
  assign issue  = !fifo_empty && has_credit && permit;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lock_d  = lock_q;
    ps_d    = 1'b0;
    psvc_d  = psvc_q;
    if (issue) begin
      if (state_q == OP_IDLE) begin
        if (total == 8'd1) begin
          ps_d   = 1'b1;
          psvc_d = hv;
        end else begin
          rem_d   = total - 8'd1;
          lock_d  = hv;
          state_d = OP_BODY;
        end
      end else if (rem_q == 8'd1) begin
        ps_d    = 1'b1;
        psvc_d  = lock_q;
        state_d = OP_IDLE;
      end else begin
        rem_d = rem_q - 8'd1;
      end
    end
  end

  always_comb begin
    ovf_hit = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc[v] = credit_granted[v];
      dec[v] = issue && (hv == VCW'(v));
      if (inc[v] && !dec[v] && cred_q[v] == CW'(BUFFER_SIZE)) ovf_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= OP_IDLE;
      rem_q       <= '0;
      lock_q      <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      ps_q        <= 1'b0;
      psvc_q      <= '0;
      ovf_q       <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CW'(BUFFER_SIZE);
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      lock_q      <= lock_d;
      out_valid_q <= issue;
      ps_q        <= ps_d;
      psvc_q      <= psvc_d;
      if (issue)   out_flit_q <= head;
      if (ovf_hit) ovf_q      <= 1'b1;
      // Grant and issue on the same VC cancel; a grant at full saturates.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (inc[v] && !dec[v] && cred_q[v] != CW'(BUFFER_SIZE))
          cred_q[v] <= cred_q[v] + 1'b1;
        else if (dec[v] && !inc[v])
          cred_q[v] <= cred_q[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) assert (fifo_cnt <= FCW'(FIFO_DEPTH));
  end

  assign out_flit        = out_flit_q;
  assign out_valid       = out_valid_q;
  assign packet_sent     = ps_q;
  assign packet_sent_vc  = psvc_q;
  assign credits         = cred_q;
  assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_switch_out_port.sv
// Scoreboard bench for switch_out_port: pushed flits queue their expected
// output and end-of-packet flag; a negedge monitor pops and compares.
module tb_switch_out_port;
  import chiplet_types_pkg::*;

  localparam int NV = 2;
  localparam int BS = 8;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 n_rst;
  flit_t                in_flit;
  logic                 in_valid, in_ready;
  logic [NV-1:0]        credit_granted;
  flit_t                out_flit;
  logic                 out_valid, packet_sent;
  logic [0:0]           packet_sent_vc;
  logic [NV-1:0][CW-1:0] credits;
  logic                 credit_overflow;

  typedef struct {
    flit_t f;
    logic  last;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  localparam logic [31:0] HDR_SW3    = {FMT_SHORT_WRITE, 24'h0, 4'd3};
  localparam logic [31:0] HDR_SINGLE = {4'hF, 21'h0, 7'd0};
  localparam logic [31:0] HDR_LR0    = {FMT_LONG_READ, 21'h0, 7'd0};
  localparam logic [31:0] HDR_LR127  = {FMT_LONG_READ, 21'h0, 7'd127};

  switch_out_port #(.NUM_VCS(NV), .BUFFER_SIZE(BS), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in_flit         (in_flit),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .credit_granted  (credit_granted),
    .out_flit        (out_flit),
    .out_valid       (out_valid),
    .packet_sent     (packet_sent),
    .packet_sent_vc  (packet_sent_vc),
    .credits         (credits),
    .credit_overflow (credit_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int exp_total(logic [31:0] p);
    case (p[31:28])
      4'h0, 4'h1: return int'(p[3:0]) + 1;
      4'h2, 4'h3: return int'(p[6:0]) + 2;
      default:    return int'(p[6:0]) + 1;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      checks++;
      if (out_valid) begin
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit got=%h exp=none", out_flit);
        end else begin
          e = sb.pop_front();
          if (out_flit !== e.f || packet_sent !== e.last ||
              (e.last && packet_sent_vc !== e.f.vc[0])) begin
            errors++;
            $display("FAIL out_flit got=%h ps=%b psvc=%0d exp=%h ps=%b", out_flit,
                     packet_sent, packet_sent_vc, e.f, e.last);
          end
        end
      end else if (packet_sent !== 1'b0) begin
        errors++;
        $display("FAIL stray_packet_sent got=%b exp=0", packet_sent);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push1(input int vc, input logic [31:0] pl, input bit last, input bit track);
    int w = 0;
    exp_t e;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout got=in_ready0 exp=in_ready1");
    end else begin
      e.f.vc = FLIT_VC_W'(vc); e.f.payload = pl; e.last = last;
      in_flit = e.f; in_valid = 1'b1;
      if (track) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic ret_credit(input bit ret);
    credit_granted = '0;
    if (ret && out_valid) credit_granted[out_flit.vc[0]] = 1'b1;
  endtask

  task automatic send_pkt(input int vc, input logic [31:0] hdr, input bit ret);
    int   tot = exp_total(hdr);
    int   i = 0;
    int   w = 0;
    exp_t e;
    while (i < tot && w < 1000) begin
      ret_credit(ret);
      if (in_ready) begin
        e.f.vc = FLIT_VC_W'(vc);
        e.f.payload = (i == 0) ? hdr : $urandom;
        e.last = (i == tot - 1);
        in_flit = e.f; in_valid = 1'b1;
        sb.push_back(e);
        i++;
      end else in_valid = 1'b0;
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b0; credit_granted = '0;
    if (i < tot) begin
      checks++; errors++;
      $display("FAIL send_timeout got=%0d exp=%0d flits", i, tot);
    end
  endtask

  task automatic drain(input bit ret, input int maxc);
    int w = 0;
    while ((sb.size() > 0 || (ret && out_valid)) && w < maxc) begin
      ret_credit(ret);
      @(posedge clk); #1; w++;
    end
    credit_granted = '0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", sb.size());
    end
  endtask

  task automatic grant(input int vc, input int n);
    repeat (n) begin
      credit_granted = '0; credit_granted[vc] = 1'b1;
      @(posedge clk); #1;
    end
    credit_granted = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got=%b exp=0", tag, out_valid); end
    checks++; if (out_flit !== '0) begin errors++; $display("FAIL %s_out_flit got=%h exp=0", tag, out_flit); end
    checks++; if (packet_sent !== 1'b0) begin errors++; $display("FAIL %s_packet_sent got=%b exp=0", tag, packet_sent); end
    checks++; if (packet_sent_vc !== 1'b0) begin errors++; $display("FAIL %s_psvc got=%b exp=0", tag, packet_sent_vc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b exp=1", tag, in_ready); end
    checks++; if (credits[0] !== CW'(BS)) begin errors++; $display("FAIL %s_credits0 got=%0d exp=%0d", tag, credits[0], BS); end
    checks++; if (credits[1] !== CW'(BS)) begin errors++; $display("FAIL %s_credits1 got=%0d exp=%0d", tag, credits[1], BS); end
    checks++; if (credit_overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow got=%b exp=0", tag, credit_overflow); end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_flit = '0; credit_granted = '0;
    repeat (2) @(posedge clk); #1;
    check_idle_outputs("reset");
    n_rst = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_short_write();
    out_cyc.delete();
    send_pkt(0, HDR_SW3, 1'b0);
    drain(1'b0, 20);
    checks++;
    if (out_cyc.size() != 4 || out_cyc[3] - out_cyc[0] != 3) begin
      errors++; $display("FAIL sw_consecutive got=%0d flits span=%0d exp=4 span=3",
                         out_cyc.size(), out_cyc[3] - out_cyc[0]);
    end
    checks++; if (credits[0] !== CW'(BS - 4)) begin errors++; $display("FAIL sw_credits got=%0d exp=%0d", credits[0], BS - 4); end
    grant(0, 4);
    checks++; if (credits[0] !== CW'(BS)) begin errors++; $display("FAIL sw_restore got=%0d exp=%0d", credits[0], BS); end
  endtask

  task automatic test_starvation();
    int gc;
    repeat (8) send_pkt(1, HDR_SINGLE, 1'b0);
    drain(1'b0, 20);
    checks++; if (credits[1] !== '0) begin errors++; $display("FAIL starve_credits got=%0d exp=0", credits[1]); end
    out_cyc.delete();
    push1(1, HDR_SINGLE, 1'b1, 1'b1);
    push1(1, HDR_SINGLE, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure_in_ready got=%b exp=0", in_ready); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (out_cyc.size() != 0) begin errors++; $display("FAIL starve_issue got=%0d exp=0", out_cyc.size()); end
    gc = cyc;
    grant(1, 1);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_cyc.size() != 1 || out_cyc[0] != gc + 2) begin
      errors++; $display("FAIL starve_resume got=%0d@%0d exp=1@%0d", out_cyc.size(), out_cyc[0], gc + 2);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL starve_ready got=%b exp=1", in_ready); end
    grant(1, 1);
    drain(1'b0, 20);
    grant(1, 8);
    checks++; if (credits[1] !== CW'(BS)) begin errors++; $display("FAIL starve_restore got=%0d exp=%0d", credits[1], BS); end
  endtask

  task automatic test_long();
    out_cyc.delete();
    send_pkt(0, HDR_LR0, 1'b1);
    drain(1'b1, 20);
    checks++; if (out_cyc.size() != 2) begin errors++; $display("FAIL long0_flits got=%0d exp=2", out_cyc.size()); end
    out_cyc.delete();
    send_pkt(1, HDR_LR127, 1'b1);
    drain(1'b1, 300);
    checks++; if (out_cyc.size() != 129) begin errors++; $display("FAIL long127_flits got=%0d exp=129", out_cyc.size()); end
    checks++; if (credits[1] !== CW'(BS)) begin errors++; $display("FAIL long_credits got=%0d exp=%0d", credits[1], BS); end
    checks++; if (credit_overflow !== 1'b0) begin errors++; $display("FAIL long_overflow got=%b exp=0", credit_overflow); end
  endtask

  task automatic test_simultaneous();
    push1(0, HDR_SINGLE, 1'b1, 1'b1);
    grant(0, 1);
    checks++; if (credits[0] !== CW'(BS)) begin errors++; $display("FAIL simul_credits got=%0d exp=%0d", credits[0], BS); end
    checks++; if (credit_overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got=%b exp=0", credit_overflow); end
    grant(0, 1);
    checks++; if (credits[0] !== CW'(BS)) begin errors++; $display("FAIL sat_credits got=%0d exp=%0d", credits[0], BS); end
    checks++; if (credit_overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b exp=1", credit_overflow); end
    drain(1'b0, 10);
  endtask

  task automatic test_reset_mid_packet();
    out_cyc.delete();
    push1(0, HDR_SW3, 1'b0, 1'b1);
    push1(0, 32'h1234_5678, 1'b0, 1'b1);
    // A different VC at the head while the VC0 body is open must not issue.
    push1(1, HDR_SINGLE, 1'b1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (out_cyc.size() != 2) begin errors++; $display("FAIL lock_hold got=%0d exp=2", out_cyc.size()); end
    #3 n_rst = 1'b0;
    #1 check_idle_outputs("midrst");
    sb.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    out_cyc.delete();
    send_pkt(0, HDR_SW3, 1'b0);
    drain(1'b0, 20);
    checks++; if (out_cyc.size() != 4) begin errors++; $display("FAIL post_rst_flits got=%0d exp=4", out_cyc.size()); end
    checks++; if (credits[0] !== CW'(BS - 4)) begin errors++; $display("FAIL post_rst_credits got=%0d exp=%0d", credits[0], BS - 4); end
  endtask

  initial begin
    test_reset();
    test_short_write();
    test_starvation();
    test_long();
    test_simultaneous();
    test_reset_mid_packet();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
